// File: rtl/glitch_pulse_gen.sv
// Glitcher timing core: after arm, waits for a trigger rising edge, counts a delay,
// then emits a train of fixed-width pulses separated by fixed gaps on glitch_out.
module glitch_pulse_gen #(
    parameter int unsigned DELAY_W = 32,
    parameter int unsigned WIDTH_W = 16,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic               abort,
    input  logic               trig_in,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [WIDTH_W-1:0] cfg_width,
    input  logic [WIDTH_W-1:0] cfg_gap,
    input  logic [COUNT_W-1:0] cfg_count,
    output logic               glitch_out,
    output logic               armed,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {StIdle, StArmed, StDelay, StPulse, StGap, StDone} state_e;

    state_e state_q, state_d;

    logic sync1_q, sync2_q, sync3_q;
    logic trig_rise;

    logic [DELAY_W-1:0] delay_sh_q, delay_sh_d;
    logic [WIDTH_W-1:0] width_sh_q, width_sh_d;
    logic [WIDTH_W-1:0] gap_sh_q, gap_sh_d;
    logic [COUNT_W-1:0] count_sh_q, count_sh_d;

    logic [DELAY_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [WIDTH_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [COUNT_W-1:0] pulses_q, pulses_d;
    logic               glitch_q, glitch_d;

    assign trig_rise = sync2_q & ~sync3_q;

    always_comb begin
        state_d     = state_q;
        delay_sh_d  = delay_sh_q;
        width_sh_d  = width_sh_q;
        gap_sh_d    = gap_sh_q;
        count_sh_d  = count_sh_q;
        delay_cnt_d = delay_cnt_q;
        phase_cnt_d = phase_cnt_q;
        pulses_d    = pulses_q;

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d    = StArmed;
                    delay_sh_d = cfg_delay;
                    // zero width/gap/count are promoted to one
                    width_sh_d = (cfg_width == '0) ? WIDTH_W'(1) : cfg_width;
                    gap_sh_d   = (cfg_gap == '0) ? WIDTH_W'(1) : cfg_gap;
                    count_sh_d = (cfg_count == '0) ? COUNT_W'(1) : cfg_count;
                end
            end
            StArmed: begin
                if (trig_rise) begin
                    state_d     = StDelay;
                    delay_cnt_d = delay_sh_q;
                    pulses_d    = count_sh_q;
                end
            end
            StDelay: begin
                if (delay_cnt_q == '0) begin
                    state_d     = StPulse;
                    phase_cnt_d = width_sh_q - WIDTH_W'(1);
                end else begin
                    delay_cnt_d = delay_cnt_q - DELAY_W'(1);
                end
            end
            StPulse: begin
                if (phase_cnt_q == '0) begin
                    pulses_d = pulses_q - COUNT_W'(1);
                    if (pulses_q == COUNT_W'(1)) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StGap;
                        phase_cnt_d = gap_sh_q - WIDTH_W'(1);
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q - WIDTH_W'(1);
                end
            end
            StGap: begin
                if (phase_cnt_q == '0) begin
                    state_d     = StPulse;
                    phase_cnt_d = width_sh_q - WIDTH_W'(1);
                end else begin
                    phase_cnt_d = phase_cnt_q - WIDTH_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d = StIdle;
        end
    end

    // Registered copy of "next state is PULSE" keeps the pad free of decode glitches.
    assign glitch_d = (state_d == StPulse);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            delay_sh_q  <= '0;
            width_sh_q  <= '0;
            gap_sh_q    <= '0;
            count_sh_q  <= '0;
            delay_cnt_q <= '0;
            phase_cnt_q <= '0;
            pulses_q    <= '0;
            glitch_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= trig_in;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            delay_sh_q  <= delay_sh_d;
            width_sh_q  <= width_sh_d;
            gap_sh_q    <= gap_sh_d;
            count_sh_q  <= count_sh_d;
            delay_cnt_q <= delay_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            pulses_q    <= pulses_d;
            glitch_q    <= glitch_d;
        end
    end

    assign glitch_out = glitch_q;
    assign armed      = (state_q == StArmed);
    assign busy       = (state_q == StDelay) || (state_q == StPulse) || (state_q == StGap);
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Randomised bench for glitch_pulse_gen; expected waveforms come from the pulse-train
// timing formula relative to T0 (first sync-stage capture of trig_in).
module tb_glitch_pulse_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        trig_in = 1'b0;
    logic [31:0] cfg_delay = '0;
    logic [15:0] cfg_width = '0;
    logic [15:0] cfg_gap = '0;
    logic [7:0]  cfg_count = '0;
    logic        glitch_out, armed, busy, done;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    glitch_pulse_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm        (arm),
        .abort      (abort),
        .trig_in    (trig_in),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_gap    (cfg_gap),
        .cfg_count  (cfg_count),
        .glitch_out (glitch_out),
        .armed      (armed),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic do_arm(input int d, input int w, input int g, input int c);
        @(negedge clk);
        cfg_delay = d;
        cfg_width = w[15:0];
        cfg_gap   = g[15:0];
        cfg_count = c[7:0];
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check_eq("armed_after_arm", {31'b0, armed}, 1);
        // Scramble the inputs; the latched copy must be used.
        cfg_delay = $urandom;
        cfg_width = 16'($urandom);
        cfg_gap   = 16'($urandom);
        cfg_count = 8'($urandom);
        repeat (3) @(negedge clk);
    endtask

    // Arms, triggers and checks every cycle of the resulting train.
    task automatic run_train(input int d, input int w, input int g, input int c, input bit tog);
        int we, ge, ce, p, t0, e, rel, done_e, rises;
        bit prev, exp_g;
        we = (w == 0) ? 1 : w;
        ge = (g == 0) ? 1 : g;
        ce = (c == 0) ? 1 : c;
        p = we + ge;
        done_e = 3 + d + (ce - 1) * p + we;
        do_arm(d, w, g, c);
        @(negedge clk);
        trig_in = 1'b1;
        t0 = cyc + 1;
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i <= done_e + 3; i++) begin
            @(posedge clk);
            #1;
            e = cyc - t0;
            rel = e - 3 - d;
            exp_g = (rel >= 0) && (rel / p < ce) && (rel % p < we);
            check_eq("glitch", {31'b0, glitch_out}, {31'b0, exp_g});
            check_eq("busy", {31'b0, busy}, {31'b0, (e >= 2 && e < done_e)});
            check_eq("done", {31'b0, done}, {31'b0, (e == done_e)});
            check_eq("armed", {31'b0, armed}, {31'b0, (e < 2)});
            if (glitch_out && !prev) rises++;
            prev = glitch_out;
            if (e == 5) trig_in = 1'b0;
            if (tog && e >= 10 && e < 40) trig_in = ~trig_in;
        end
        check_eq("pulse_count", rises, ce);
    endtask

    initial begin
        int t0;
        #2;
        check_eq("rst_glitch", {31'b0, glitch_out}, 0);
        check_eq("rst_armed", {31'b0, armed}, 0);
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_done", {31'b0, done}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Trigger edges while idle must be discarded.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            trig_in = i[1];
            check_eq("idle_glitch", {31'b0, glitch_out}, 0);
            check_eq("idle_state", {30'b0, armed, busy}, 0);
        end
        trig_in = 1'b0;
        repeat (4) @(negedge clk);

        run_train(10, 4, 1, 1, 1'b0);
        run_train(0, 2, 3, 3, 1'b0);
        run_train(7, 0, 0, 0, 1'b0);
        run_train(100, 3, 2, 2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_train($urandom_range(0, 20), $urandom_range(0, 5), $urandom_range(0, 5),
                      $urandom_range(0, 4), 1'b0);
        end

        // Abort in cycle 20 of the first pulse.
        do_arm(5, 50, 2, 2);
        @(negedge clk);
        trig_in = 1'b1;
        t0 = cyc + 1;
        repeat (3 + 5 + 20 + 1) @(posedge clk);
        #1;
        check_eq("abort_pre_glitch", {31'b0, glitch_out}, 1);
        check_eq("abort_cycle", cyc - t0, 3 + 5 + 20);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        trig_in = 1'b0;
        check_eq("abort_glitch", {31'b0, glitch_out}, 0);
        check_eq("abort_state", {29'b0, armed, busy, done}, 0);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            check_eq("abort_no_done", {30'b0, done, glitch_out}, 0);
        end

        // Arm together with abort: abort wins.
        @(negedge clk);
        arm = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        abort = 1'b0;
        check_eq("arm_abort_idle", {31'b0, armed}, 0);
        repeat (2) @(negedge clk);

        run_train(3, 2, 1, 2, 1'b0);

        // Asynchronous reset mid-pulse.
        do_arm(2, 20, 1, 1);
        @(negedge clk);
        trig_in = 1'b1;
        t0 = cyc + 1;
        repeat (3 + 2 + 5 + 1) @(posedge clk);
        #1;
        check_eq("rst_pre_glitch", {31'b0, glitch_out}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_glitch", {31'b0, glitch_out}, 0);
        check_eq("async_rst_outs", {29'b0, armed, busy, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        trig_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            trig_in = i[0];
            check_eq("post_rst_idle", {29'b0, glitch_out, armed, busy}, 0);
        end
        trig_in = 1'b0;
        repeat (4) @(negedge clk);

        run_train(1, 1, 1, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
